add_sub_rs: RTL and testbench

- Reservation station in front of the pipelined add/sub unit.
- Accepts dispatched add/sub ops whose operands may still be pending.
- Captures missing operands and carry from the common result bus (CDB) and issues ready ops to the unit over a valid/ready handshake.
- Owns the unit's rs_id space: each entry has a fixed tag, and that tag is released only when the entry's own result appears on the CDB.

---
 rtl/add_sub_rs.sv | 217 +++++++++++++++++++++
 tb/tb_add_sub_rs.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_rs.sv
// rtl/add_sub_rs.sv - reservation station feeding the pipelined add/sub unit

package add_sub_pkg;
  typedef struct packed {
    logic is_sub;
    logic use_carry;
  } add_sub_decode_t;
endpackage

module add_sub_rs
  import add_sub_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_ID_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [4:0]             dispatch_reg_addr,
  input  add_sub_decode_t        dispatch_control,
  input  logic [31:0]            dispatch_op1,
  input  logic [31:0]            dispatch_op2,
  input  logic                   dispatch_op1_valid,
  input  logic                   dispatch_op2_valid,
  input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag,
  input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag,
  input  logic                   dispatch_ca,
  input  logic                   dispatch_ca_valid,
  input  logic [RS_ID_WIDTH-1:0] dispatch_ca_tag,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic                   cdb_ca,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic                   issue_ca,
  output add_sub_decode_t        issue_control
);

  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} state_t;

  state_t                 state_q   [NUM_ENTRIES];
  logic [4:0]             reg_addr_q[NUM_ENTRIES];
  add_sub_decode_t        control_q [NUM_ENTRIES];
  logic [31:0]            op1_q     [NUM_ENTRIES];
  logic [31:0]            op2_q     [NUM_ENTRIES];
  logic                   ca_q      [NUM_ENTRIES];
  logic                   op1_v_q   [NUM_ENTRIES];
  logic                   op2_v_q   [NUM_ENTRIES];
  logic                   ca_v_q    [NUM_ENTRIES];
  logic [RS_ID_WIDTH-1:0] op1_tag_q [NUM_ENTRIES];
  logic [RS_ID_WIDTH-1:0] op2_tag_q [NUM_ENTRIES];
  logic [RS_ID_WIDTH-1:0] ca_tag_q  [NUM_ENTRIES];
  logic [IW-1:0]          rr_ptr_q;

  logic [NUM_ENTRIES-1:0] free_vec, ready_vec, cap1, cap2, capc, own_hit;
  logic [IW-1:0]          alloc_idx, sel_idx, probe_idx;
  logic                   sel_found, dispatch_fire, issue_fire;
  logic                   d_op1_v, d_op2_v, d_ca_v, d_all_v;
  logic [31:0]            d_op1, d_op2;
  logic                   d_ca;
  int                     probe;

  // Per-entry status decode and CDB tag matches (captures only matter in WAIT)
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    cap1      = '0;
    cap2      = '0;
    capc      = '0;
    own_hit   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i]  = (state_q[i] == S_FREE);
      ready_vec[i] = (state_q[i] == S_READY);
      cap1[i]      = cdb_valid && !op1_v_q[i] && (op1_tag_q[i] == cdb_rs_id);
      cap2[i]      = cdb_valid && !op2_v_q[i] && (op2_tag_q[i] == cdb_rs_id);
      capc[i]      = cdb_valid && !ca_v_q[i]  && (ca_tag_q[i]  == cdb_rs_id);
      own_hit[i]   = cdb_valid && (cdb_rs_id == RS_ID_WIDTH'(RS_ID_BASE + i));
    end
  end

  // Lowest-index free entry receives the next dispatch
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IW'(i);
    end
  end

  assign dispatch_ready = |free_vec;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  // Dispatch bypass: a slot waiting on the tag being broadcast right now is born valid
  always_comb begin
    d_op1_v = dispatch_op1_valid || (cdb_valid && (dispatch_op1_tag == cdb_rs_id));
    d_op2_v = dispatch_op2_valid || (cdb_valid && (dispatch_op2_tag == cdb_rs_id));
    d_ca_v  = dispatch_ca_valid  || (cdb_valid && (dispatch_ca_tag  == cdb_rs_id));
    d_op1   = dispatch_op1_valid ? dispatch_op1 : cdb_result;
    d_op2   = dispatch_op2_valid ? dispatch_op2 : cdb_result;
    d_ca    = dispatch_ca_valid  ? dispatch_ca  : cdb_ca;
    d_all_v = d_op1_v && d_op2_v && d_ca_v;
  end

  // Round-robin pick of the first READY entry at or after the pointer
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    probe     = 0;
    probe_idx = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      probe = int'(rr_ptr_q) + k;
      if (probe >= NUM_ENTRIES) probe = probe - NUM_ENTRIES;
      probe_idx = IW'(probe);
      if (!sel_found && ready_vec[probe_idx]) begin
        sel_found = 1'b1;
        sel_idx   = probe_idx;
      end
    end
  end

  assign issue_valid = sel_found;
  assign issue_fire  = sel_found && issue_ready;

  // Issue payload muxed from the selected entry; zero when nothing is ready
  always_comb begin
    issue_rs_id    = '0;
    issue_reg_addr = '0;
    issue_op1      = '0;
    issue_op2      = '0;
    issue_ca       = 1'b0;
    issue_control  = '0;
    if (sel_found) begin
      issue_rs_id    = RS_ID_WIDTH'(RS_ID_BASE) + RS_ID_WIDTH'(sel_idx);
      issue_reg_addr = reg_addr_q[sel_idx];
      issue_op1      = op1_q[sel_idx];
      issue_op2      = op2_q[sel_idx];
      issue_ca       = ca_q[sel_idx];
      issue_control  = control_q[sel_idx];
    end
  end

  // Per-entry state machine: allocation, CDB capture, issue and tag release
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i]    <= S_FREE;
        reg_addr_q[i] <= '0;
        control_q[i]  <= '0;
        op1_q[i]      <= '0;
        op2_q[i]      <= '0;
        ca_q[i]       <= 1'b0;
        op1_v_q[i]    <= 1'b0;
        op2_v_q[i]    <= 1'b0;
        ca_v_q[i]     <= 1'b0;
        op1_tag_q[i]  <= '0;
        op2_tag_q[i]  <= '0;
        ca_tag_q[i]   <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        case (state_q[i])
          S_FREE: begin
            if (dispatch_fire && (alloc_idx == IW'(i))) begin
              reg_addr_q[i] <= dispatch_reg_addr;
              control_q[i]  <= dispatch_control;
              op1_q[i]      <= d_op1;
              op2_q[i]      <= d_op2;
              ca_q[i]       <= d_ca;
              op1_v_q[i]    <= d_op1_v;
              op2_v_q[i]    <= d_op2_v;
              ca_v_q[i]     <= d_ca_v;
              op1_tag_q[i]  <= dispatch_op1_tag;
              op2_tag_q[i]  <= dispatch_op2_tag;
              ca_tag_q[i]   <= dispatch_ca_tag;
              state_q[i]    <= d_all_v ? S_READY : S_WAIT;
            end
          end
          S_WAIT: begin
            if (cap1[i]) begin
              op1_q[i]   <= cdb_result;
              op1_v_q[i] <= 1'b1;
            end
            if (cap2[i]) begin
              op2_q[i]   <= cdb_result;
              op2_v_q[i] <= 1'b1;
            end
            if (capc[i]) begin
              ca_q[i]   <= cdb_ca;
              ca_v_q[i] <= 1'b1;
            end
            if ((op1_v_q[i] || cap1[i]) && (op2_v_q[i] || cap2[i]) && (ca_v_q[i] || capc[i]))
              state_q[i] <= S_READY;
          end
          S_READY: begin
            if (issue_fire && (sel_idx == IW'(i))) state_q[i] <= S_ISSUED;
          end
          S_ISSUED: begin
            if (own_hit[i]) state_q[i] <= S_FREE;
          end
          default: state_q[i] <= S_FREE;
        endcase
      end
      if (issue_fire)
        rr_ptr_q <= (sel_idx == IW'(NUM_ENTRIES - 1)) ? '0 : sel_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_add_sub_rs.sv
// tb/tb_add_sub_rs.sv - self-checking bench for add_sub_rs

module tb_add_sub_rs;
  import add_sub_pkg::*;

  localparam int N    = 4;
  localparam int TW   = 5;
  localparam int BASE = 16;

  localparam add_sub_decode_t C_ADD = 2'b00;
  localparam add_sub_decode_t C_SUB = 2'b10;
  localparam add_sub_decode_t C_ADC = 2'b01;

  logic            clk, rst;
  logic            dispatch_valid, dispatch_ready;
  logic [4:0]      dispatch_reg_addr;
  add_sub_decode_t dispatch_control;
  logic [31:0]     dispatch_op1, dispatch_op2;
  logic            dispatch_op1_valid, dispatch_op2_valid;
  logic [TW-1:0]   dispatch_op1_tag, dispatch_op2_tag;
  logic            dispatch_ca, dispatch_ca_valid;
  logic [TW-1:0]   dispatch_ca_tag;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_rs_id;
  logic [31:0]     cdb_result;
  logic            cdb_ca;
  logic            issue_valid, issue_ready;
  logic [TW-1:0]   issue_rs_id;
  logic [4:0]      issue_reg_addr;
  logic [31:0]     issue_op1, issue_op2;
  logic            issue_ca;
  add_sub_decode_t issue_control;

  add_sub_rs #(.NUM_ENTRIES(N), .RS_ID_WIDTH(TW), .RS_ID_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_reg_addr(dispatch_reg_addr), .dispatch_control(dispatch_control),
    .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2),
    .dispatch_op1_valid(dispatch_op1_valid), .dispatch_op2_valid(dispatch_op2_valid),
    .dispatch_op1_tag(dispatch_op1_tag), .dispatch_op2_tag(dispatch_op2_tag),
    .dispatch_ca(dispatch_ca), .dispatch_ca_valid(dispatch_ca_valid),
    .dispatch_ca_tag(dispatch_ca_tag),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result), .cdb_ca(cdb_ca),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
    .issue_reg_addr(issue_reg_addr), .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_ca(issue_ca), .issue_control(issue_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Model: one record per tag-owning slot, tracking which operands are still owed
  bit              m_busy[N], m_iss[N], m_n1[N], m_n2[N], m_nc[N];
  logic [31:0]     m_op1[N], m_op2[N];
  logic            m_ca[N];
  logic [TW-1:0]   m_t1[N], m_t2[N], m_tc[N];
  logic [4:0]      m_reg[N];
  add_sub_decode_t m_ctl[N];
  int              m_ptr;

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      int e;
      e = (m_ptr + k) % N;
      if (m_busy[e] && !m_iss[e] && !m_n1[e] && !m_n2[e] && !m_nc[e]) return e;
    end
    return -1;
  endfunction

  function automatic int m_free();
    for (int e = 0; e < N; e++) if (!m_busy[e]) return e;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int pk, fr;
    if (rst) begin
      for (int e = 0; e < N; e++) begin
        m_busy[e] = 0; m_iss[e] = 0; m_n1[e] = 0; m_n2[e] = 0; m_nc[e] = 0;
      end
      m_ptr = 0;
    end else begin
      pk = m_pick();
      fr = m_free();
      if (cdb_valid && cdb_rs_id >= BASE && cdb_rs_id < BASE + N)
        check("cdb_own_tag_only_when_issued", m_iss[cdb_rs_id - BASE], 1);
      for (int e = 0; e < N; e++)
        if (cdb_valid && m_busy[e] && m_iss[e] && cdb_rs_id == TW'(BASE + e)) begin
          m_busy[e] = 0; m_iss[e] = 0;
        end
      if (issue_ready && pk >= 0) begin
        m_iss[pk] = 1;
        m_ptr = (pk + 1) % N;
      end
      for (int e = 0; e < N; e++)
        if (cdb_valid && m_busy[e] && !m_iss[e]) begin
          if (m_n1[e] && m_t1[e] == cdb_rs_id) begin m_op1[e] = cdb_result; m_n1[e] = 0; end
          if (m_n2[e] && m_t2[e] == cdb_rs_id) begin m_op2[e] = cdb_result; m_n2[e] = 0; end
          if (m_nc[e] && m_tc[e] == cdb_rs_id) begin m_ca[e]  = cdb_ca;     m_nc[e] = 0; end
        end
      if (dispatch_valid && fr >= 0) begin
        m_busy[fr] = 1; m_iss[fr] = 0;
        m_reg[fr] = dispatch_reg_addr; m_ctl[fr] = dispatch_control;
        m_t1[fr] = dispatch_op1_tag; m_t2[fr] = dispatch_op2_tag; m_tc[fr] = dispatch_ca_tag;
        m_n1[fr] = !dispatch_op1_valid; m_n2[fr] = !dispatch_op2_valid; m_nc[fr] = !dispatch_ca_valid;
        m_op1[fr] = dispatch_op1; m_op2[fr] = dispatch_op2; m_ca[fr] = dispatch_ca;
        if (m_n1[fr] && cdb_valid && m_t1[fr] == cdb_rs_id) begin m_op1[fr] = cdb_result; m_n1[fr] = 0; end
        if (m_n2[fr] && cdb_valid && m_t2[fr] == cdb_rs_id) begin m_op2[fr] = cdb_result; m_n2[fr] = 0; end
        if (m_nc[fr] && cdb_valid && m_tc[fr] == cdb_rs_id) begin m_ca[fr]  = cdb_ca;     m_nc[fr] = 0; end
      end
    end
  end

  always @(negedge clk) begin : compare
    int pk, fr;
    if (!rst) begin
      pk = m_pick();
      fr = m_free();
      check("dispatch_ready", dispatch_ready, fr >= 0);
      check("issue_valid", issue_valid, pk >= 0);
      if (pk >= 0) begin
        check("issue_rs_id", issue_rs_id, BASE + pk);
        check("issue_reg_addr", issue_reg_addr, m_reg[pk]);
        check("issue_op1", issue_op1, m_op1[pk]);
        check("issue_op2", issue_op2, m_op2[pk]);
        check("issue_ca", issue_ca, m_ca[pk]);
        check("issue_control", issue_control, m_ctl[pk]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
  endtask

  task automatic disp(input logic [4:0] ra, input add_sub_decode_t c,
                      input logic [31:0] a, input logic av, input logic [TW-1:0] at,
                      input logic [31:0] b, input logic bv, input logic [TW-1:0] bt,
                      input logic cc, input logic cv, input logic [TW-1:0] ct);
    dispatch_valid = 1'b1;
    dispatch_reg_addr = ra; dispatch_control = c;
    dispatch_op1 = a; dispatch_op1_valid = av; dispatch_op1_tag = at;
    dispatch_op2 = b; dispatch_op2_valid = bv; dispatch_op2_tag = bt;
    dispatch_ca = cc; dispatch_ca_valid = cv; dispatch_ca_tag = ct;
  endtask

  task automatic cdb(input logic [TW-1:0] t, input logic [31:0] r, input logic c);
    cdb_valid = 1'b1; cdb_rs_id = t; cdb_result = r; cdb_ca = c;
  endtask

  initial begin
    rst = 1'b1; issue_ready = 1'b0;
    dispatch_valid = 0; dispatch_reg_addr = 0; dispatch_control = C_ADD;
    dispatch_op1 = 0; dispatch_op2 = 0; dispatch_op1_valid = 0; dispatch_op2_valid = 0;
    dispatch_op1_tag = 0; dispatch_op2_tag = 0;
    dispatch_ca = 0; dispatch_ca_valid = 0; dispatch_ca_tag = 0;
    cdb_valid = 0; cdb_rs_id = 0; cdb_result = 0; cdb_ca = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_dispatch_ready", dispatch_ready, 1);
    check("reset_issue_valid", issue_valid, 0);
    check("reset_issue_op1", issue_op1, 0);
    check("reset_issue_rs_id", issue_rs_id, 0);

    // all operands present: issue the next cycle
    issue_ready = 1'b1;
    disp(5'd1, C_ADD, 32'd5, 1, 0, 32'd7, 1, 0, 0, 1, 0); step();
    check("basic_issue_valid", issue_valid, 1);
    check("basic_rs_id", issue_rs_id, 16);
    check("basic_op1", issue_op1, 5);
    check("basic_op2", issue_op2, 7);
    step();
    check("basic_drained", issue_valid, 0);
    cdb(5'd16, 32'd12, 0); step();

    // op2 waits on tag 9, captured two cycles later
    disp(5'd2, C_SUB, 32'd100, 1, 0, 32'd0, 0, 5'd9, 0, 1, 0); step();
    check("wait_cycle1", issue_valid, 0); step();
    check("wait_cycle2", issue_valid, 0);
    cdb(5'd9, 32'h1234, 0); step();
    check("capture_issue_valid", issue_valid, 1);
    check("capture_op2", issue_op2, 32'h1234);
    check("capture_op1", issue_op1, 100);
    step();
    cdb(5'd16, 32'd0, 0); step();

    // carry bypassed from the CDB in the dispatch cycle
    disp(5'd3, C_ADC, 32'd1, 1, 0, 32'd2, 1, 0, 0, 0, 5'd3);
    cdb(5'd3, 32'hdead, 1); step();
    check("bypass_issue_valid", issue_valid, 1);
    check("bypass_ca", issue_ca, 1);
    check("bypass_rs_id", issue_rs_id, 16);
    step();
    cdb(5'd16, 32'd0, 0); step();

    // fill, reject a fifth, then drain in round-robin order
    issue_ready = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      disp(5'(10 + i), C_ADD, 32'(100 + i), 1, 0, 32'(200 + i), 1, 0, 0, 1, 0); step();
    end
    check("full_not_ready", dispatch_ready, 0);
    disp(5'd20, C_SUB, 32'd999, 1, 0, 32'd999, 1, 0, 0, 1, 0); step();
    check("fifth_ignored_ready", dispatch_ready, 0);
    check("fifth_ignored_op1", issue_op1, 100);
    issue_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      check("rr_order_id", issue_rs_id, 16 + i);
      check("rr_order_op1", issue_op1, 100 + i);
      step();
    end
    issue_ready = 1'b0;
    check("all_issued_valid", issue_valid, 0);
    check("all_issued_ready", dispatch_ready, 0);
    cdb(5'd17, 32'd0, 0);
    check("release_same_cycle", dispatch_ready, 0);
    step();
    check("release_next_cycle", dispatch_ready, 1);
    cdb(5'd16, 32'd0, 0); step();
    cdb(5'd18, 32'd0, 0); step();
    cdb(5'd19, 32'd0, 0); step();

    // entries 0 and 2 READY with pointer at 1
    disp(5'd30, C_ADD, 32'd7, 1, 0, 32'd8, 1, 0, 0, 1, 0); step();
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    disp(5'd31, C_ADD, 32'd0, 0, 5'd9, 32'd1, 1, 0, 0, 1, 0); step();
    disp(5'd32, C_SUB, 32'd50, 1, 0, 32'd60, 1, 0, 0, 1, 0);
    cdb(5'd16, 32'd0, 0); step();
    disp(5'd33, C_ADD, 32'd70, 1, 0, 32'd80, 1, 0, 0, 1, 0); step();
    check("rr_skip_id", issue_rs_id, 18);
    check("rr_skip_op1", issue_op1, 50);
    step();
    check("rr_hold_id", issue_rs_id, 18);
    issue_ready = 1'b1; step();
    check("rr_wrap_id", issue_rs_id, 16);
    check("rr_wrap_op1", issue_op1, 70);
    step(); issue_ready = 1'b0;
    check("rr_left_waiting", issue_valid, 0);

    // reset with entries WAIT/ISSUED in flight
    rst = 1'b1; step();
    check("midreset_ready", dispatch_ready, 1);
    check("midreset_issue_valid", issue_valid, 0);
    check("midreset_issue_op1", issue_op1, 0);
    rst = 1'b0;
    disp(5'd40, C_ADD, 32'd3, 1, 0, 32'd4, 1, 0, 0, 1, 0); issue_ready = 1'b1; step();
    check("postreset_rs_id", issue_rs_id, 16);
    check("postreset_op1", issue_op1, 3);
    step();
    cdb(5'd16, 32'd0, 0); step();
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
